// File: rtl/frame_parser_param.sv
// Frame parser: hunts the header, latches a one-hot channel, buffers a trailer-delimited payload, checks CRC-16.
// Latency: frame on out_* 1 cycle after T_LO; a held frame is never overwritten, so new frames overrun (code 5).
module frame_parser_param #(
    parameter int          N_CH      = 8,
    parameter int          MAX_WORDS = 8,
    parameter logic [31:0] HEADER    = 32'hE0E0E0E0,
    parameter logic [31:0] TRAILER   = 32'h0E0E0E0E,
    parameter int          TIMEOUT   = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic [15:0]               data_in,
    input  logic                      in_vld,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_CH-1:0]           out_ch,
    output logic [4:0]                out_len,
    output logic [16*MAX_WORDS-1:0]   out_data,
    output logic                      crc_valid,
    output logic                      crc_err,
    output logic [2:0]                err_code,
    output logic [15:0]               frm_ok_cnt,
    output logic [15:0]               frm_drop_cnt
);
    localparam int          BW      = 16 * (MAX_WORDS + 1);
    localparam logic [15:0] H_HI    = HEADER[31:16];
    localparam logic [15:0] H_LO    = HEADER[15:0];
    localparam logic [15:0] T_HI    = TRAILER[31:16];
    localparam logic [15:0] T_LO    = TRAILER[15:0];
    localparam logic [5:0]  CNT_MAX = 6'(MAX_WORDS + 1);

    typedef enum logic [2:0] {S_HUNT, S_HDR2, S_CHAN, S_BODY, S_TRL} state_t;

    function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [BW-1:0]     buf_q, buf_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [15:0]       crc_q, crc_d, prev_q, prev_d;
    logic [N_CH-1:0]   ch_q, ch_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              vld_q, vld_d;
    logic [N_CH-1:0]   och_q, och_d;
    logic [4:0]        len_q, len_d;
    logic [BW-17:0]    odata_q, odata_d;
    logic              cv_q, cv_d, ce_q, ce_d;
    logic [2:0]        ec_q, ec_d;
    logic [15:0]       ok_q, ok_d, drop_q, drop_d;

    logic [1:0]        npush;
    logic [15:0]       w0, w1;
    logic              err;
    logic [2:0]        ecode;
    logic              ch_ok;
    logic [31:0]       din32;

    assign din32 = {16'd0, data_in};
    assign ch_ok = (data_in != 16'd0) && ((data_in & (data_in - 16'd1)) == 16'd0)
                   && ((din32 >> N_CH) == 32'd0);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        prev_d  = prev_q;
        ch_d    = ch_q;
        tmo_d   = tmo_q;
        vld_d   = vld_q;
        och_d   = och_q;
        len_d   = len_q;
        odata_d = odata_q;
        cv_d    = 1'b0;
        ce_d    = 1'b0;
        ec_d    = 3'd0;
        ok_d    = ok_q;
        drop_d  = drop_q;
        npush   = 2'd0;
        w0      = data_in;
        w1      = data_in;
        err     = 1'b0;
        ecode   = 3'd0;

        if (vld_q && out_ready) vld_d = 1'b0;

        if (in_vld) begin
            tmo_d = 32'd0;
            case (state_q)
                S_HUNT: if (data_in == H_HI) state_d = S_HDR2;
                S_HDR2: begin
                    if (data_in == H_LO)      state_d = S_CHAN;
                    else if (data_in != H_HI) state_d = S_HUNT;
                end
                S_CHAN: begin
                    if (ch_ok) begin
                        ch_d    = data_in[N_CH-1:0];
                        buf_d   = '0;
                        cnt_d   = 6'd0;
                        crc_d   = 16'd0;
                        prev_d  = 16'd0;
                        state_d = S_BODY;
                    end else begin
                        err     = 1'b1;
                        ecode   = 3'd2;
                        state_d = S_HUNT;
                    end
                end
                S_BODY: begin
                    if (data_in == T_HI) state_d = S_TRL;
                    else                 npush   = 2'd1;
                end
                S_TRL: begin
                    if (data_in == T_LO) begin
                        // prev_q is the CRC over everything before the received CRC word
                        state_d = S_HUNT;
                        if (cnt_q < 6'd2) begin
                            err = 1'b1; ecode = 3'd3;
                        end else if (buf_q[15:0] != prev_q) begin
                            err = 1'b1; ecode = 3'd1;
                        end else if (vld_q && !out_ready) begin
                            err = 1'b1; ecode = 3'd5;
                        end else begin
                            vld_d   = 1'b1;
                            och_d   = ch_q;
                            len_d   = 5'(cnt_q - 6'd1);
                            odata_d = buf_q[BW-1:16];
                            cv_d    = 1'b1;
                            if (ok_q != 16'hFFFF) ok_d = ok_q + 16'd1;
                        end
                    end else begin
                        w0 = T_HI;
                        if (data_in == T_HI) begin
                            npush = 2'd1;
                        end else begin
                            npush   = 2'd2;
                            state_d = S_BODY;
                        end
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end else if (TIMEOUT != 0 && state_q != S_HUNT) begin
            tmo_d = tmo_q + 32'd1;
            if (tmo_d == 32'(TIMEOUT)) begin
                err     = 1'b1;
                ecode   = 3'd4;
                state_d = S_HUNT;
                tmo_d   = 32'd0;
            end
        end

        if (npush != 2'd0) begin
            prev_d = crc_q;
            crc_d  = crc16(crc_q, w0);
            buf_d  = {buf_q[BW-17:0], w0};
            if (npush == 2'd2) begin
                prev_d = crc_d;
                crc_d  = crc16(crc_d, w1);
                buf_d  = {buf_d[BW-17:0], w1};
            end
            cnt_d = cnt_q + {4'd0, npush};
            if (cnt_d > CNT_MAX) begin
                err     = 1'b1;
                ecode   = 3'd3;
                state_d = S_HUNT;
            end
        end

        if (state_d == S_HUNT) tmo_d = 32'd0;

        if (err) begin
            ce_d = 1'b1;
            ec_d = ecode;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            buf_q   <= '0;
            cnt_q   <= 6'd0;
            crc_q   <= 16'd0;
            prev_q  <= 16'd0;
            ch_q    <= '0;
            tmo_q   <= 32'd0;
            vld_q   <= 1'b0;
            och_q   <= '0;
            len_q   <= 5'd0;
            odata_q <= '0;
            cv_q    <= 1'b0;
            ce_q    <= 1'b0;
            ec_q    <= 3'd0;
            ok_q    <= 16'd0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            prev_q  <= prev_d;
            ch_q    <= ch_d;
            tmo_q   <= tmo_d;
            vld_q   <= vld_d;
            och_q   <= och_d;
            len_q   <= len_d;
            odata_q <= odata_d;
            cv_q    <= cv_d;
            ce_q    <= ce_d;
            ec_q    <= ec_d;
            ok_q    <= ok_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid    = vld_q;
    assign out_ch       = och_q;
    assign out_len      = len_q;
    assign out_data     = odata_q;
    assign crc_valid    = cv_q;
    assign crc_err      = ce_q;
    assign err_code     = ec_q;
    assign frm_ok_cnt   = ok_q;
    assign frm_drop_cnt = drop_q;
endmodule

// File: tb/tb_frame_parser_param.sv
// Randomized and directed bench for frame_parser_param against a frame-level reference model.
module tb_frame_parser_param;
    localparam int N_CH = 8;
    localparam int MAXW = 8;
    localparam logic [15:0] H_HI = 16'hE0E0;
    localparam logic [15:0] H_LO = 16'hE0E0;
    localparam logic [15:0] T_HI = 16'h0E0E;
    localparam logic [15:0] T_LO = 16'h0E0E;

    logic                 clk_in = 1'b0;
    logic                 rst_n = 1'b0;
    logic [15:0]          data_in = 16'd0;
    logic                 in_vld = 1'b0;
    logic                 out_ready = 1'b1;
    logic                 out_valid;
    logic [N_CH-1:0]      out_ch;
    logic [4:0]           out_len;
    logic [16*MAXW-1:0]   out_data;
    logic                 crc_valid, crc_err;
    logic [2:0]           err_code;
    logic [15:0]          frm_ok_cnt, frm_drop_cnt;

    frame_parser_param #(.N_CH(N_CH), .MAX_WORDS(MAXW)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(data_in), .in_vld(in_vld),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_len(out_len),
        .out_data(out_data), .crc_valid(crc_valid), .crc_err(crc_err), .err_code(err_code),
        .frm_ok_cnt(frm_ok_cnt), .frm_drop_cnt(frm_drop_cnt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]         code;
        logic [N_CH-1:0]    ch;
        logic [4:0]         len;
        logic [16*MAXW-1:0] data;
    } ev_t;

    ev_t ev_q[$];
    bit  both_hi = 1'b0;
    int  n_chk = 0;
    int  n_fail = 0;

    // Frame-level model state
    int                 m_ok = 0, m_drop = 0;
    bit                 m_held = 1'b0;
    logic [N_CH-1:0]    m_ch = '0;
    logic [4:0]         m_len = '0;
    logic [16*MAXW-1:0] m_data = '0;
    logic [15:0]        pl [0:19];

    always @(negedge clk_in) begin : mon
        ev_t e;
        if (crc_valid && crc_err) both_hi = 1'b1;
        if (crc_err) begin
            e.code = err_code; e.ch = '0; e.len = '0; e.data = '0;
            ev_q.push_back(e);
        end
        if (crc_valid) begin
            e.code = 3'd0; e.ch = out_ch; e.len = out_len; e.data = out_data;
            ev_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] r;
        bit fb;
        r = 16'd0;
        for (int i = 0; i < n; i++)
            for (int b = 15; b >= 0; b--) begin
                fb = r[15] ^ pl[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h1021;
            end
        return r;
    endfunction

    function automatic logic [127:0] exp_data(input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[111:0], pl[i]};
        return r;
    endfunction

    function automatic int model_code(input logic [15:0] chw, input int n, input logic [15:0] crcw);
        if ($countones(chw) != 1 || int'(chw) >= (1 << N_CH)) return 2;
        if (n + 1 > MAXW + 1 || n + 1 < 2) return 3;
        if (crcw != ref_crc(n)) return 1;
        if (m_held && !out_ready) return 5;
        return 0;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        do w = 16'($urandom); while (w == H_HI || w == T_HI);
        return w;
    endfunction

    task automatic send_word(input logic [15:0] w, input int gap);
        data_in = w;
        in_vld  = 1'b1;
        @(posedge clk_in); #1;
        in_vld  = 1'b0;
        data_in = 16'($urandom);
        repeat (gap) begin @(posedge clk_in); #1; end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] chw, input int n,
                             input logic [15:0] crcw, input int gapmax);
        int  code;
        ev_t e;
        code = model_code(chw, n, crcw);
        ev_q.delete();
        send_word(H_HI, $urandom_range(gapmax, 0));
        send_word(H_LO, $urandom_range(gapmax, 0));
        send_word(chw, $urandom_range(gapmax, 0));
        for (int i = 0; i < n; i++) send_word(pl[i], $urandom_range(gapmax, 0));
        send_word(crcw, $urandom_range(gapmax, 0));
        send_word(T_HI, $urandom_range(gapmax, 0));
        send_word(T_LO, 0);
        if (code == 0) begin
            chk({tag, ".lat_valid"}, out_valid, 1);
            chk({tag, ".lat_crcv"}, crc_valid, 1);
        end
        repeat (3) begin @(posedge clk_in); #1; end
        chk({tag, ".events"}, ev_q.size(), 1);
        if (ev_q.size() != 0) begin
            e = ev_q.pop_front();
            chk({tag, ".code"}, e.code, code);
            if (code == 0 && e.code == 3'd0) begin
                chk({tag, ".ch"}, e.ch, chw[N_CH-1:0]);
                chk({tag, ".len"}, e.len, n);
                chk({tag, ".data"}, e.data, exp_data(n));
            end
        end
        if (code == 0) begin
            m_ok++; m_held = 1'b1;
            m_ch = chw[N_CH-1:0]; m_len = 5'(n); m_data = exp_data(n);
        end else begin
            m_drop++;
        end
        if (out_ready) m_held = 1'b0;
        chk({tag, ".out_valid"}, out_valid, m_held);
        if (m_held) begin
            chk({tag, ".held_data"}, out_data, m_data);
            chk({tag, ".held_ch"}, out_ch, m_ch);
        end
        chk({tag, ".ok_cnt"}, frm_ok_cnt, m_ok);
        chk({tag, ".drop_cnt"}, frm_drop_cnt, m_drop);
    endtask

    task automatic fill_valid(input int n);
        logic [15:0] c;
        do begin
            for (int i = 0; i < n; i++) pl[i] = rand_word();
            c = ref_crc(n);
        end while (c == H_HI || c == T_HI);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] c, bad;
        int          kind, n;
        bit          stable;
        logic [15:0] chw;

        repeat (3) @(posedge clk_in);
        #1 rst_n = 1'b1;
        @(negedge clk_in);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.crc_err", crc_err, 0);
        chk("rst.crc_valid", crc_valid, 0);
        chk("rst.ok_cnt", frm_ok_cnt, 0);
        chk("rst.drop_cnt", frm_drop_cnt, 0);
        chk("rst.out_data", out_data, 0);
        @(posedge clk_in); #1;

        // 1: single word payload with known CRC
        out_ready = 1'b1;
        pl[0] = 16'h0001;
        run_frame("t1", 16'h0001, 1, 16'h1021, 0);

        // 2: held frame under backpressure, then overrun
        out_ready = 1'b0;
        pl[0] = 16'h0123; pl[1] = 16'h4567; pl[2] = 16'h89AB; pl[3] = 16'hCDEF;
        pl[4] = 16'hFEDC; pl[5] = 16'hBA98; pl[6] = 16'h7654; pl[7] = 16'h3210;
        run_frame("t2a", 16'h0002, 8, ref_crc(8), 1);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk_in);
            if (!out_valid || out_data !== m_data || out_ch !== m_ch || out_len !== m_len) stable = 1'b0;
        end
        @(posedge clk_in); #1;
        chk("t2.stable", stable, 1);
        fill_valid(3);
        run_frame("t2b", 16'h0004, 3, ref_crc(3), 0);
        out_ready = 1'b1;
        @(posedge clk_in); #1;
        chk("t2.released", out_valid, 0);
        m_held = 1'b0;

        // 3: bad CRC
        pl[0] = 16'h0001;
        run_frame("t3", 16'h0001, 1, 16'hFFFF, 0);

        // 4: channel and length errors, trailer/header look-alikes as data
        fill_valid(2);
        run_frame("t4a", 16'h0003, 2, ref_crc(2), 0);
        run_frame("t4b", 16'h0100, 2, ref_crc(2), 0);
        fill_valid(9);
        run_frame("t4c", 16'h0010, 9, ref_crc(9), 0);
        pl[0] = 16'h0E0E; pl[1] = 16'h1234;
        run_frame("t4d", 16'h0020, 2, ref_crc(2), 0);
        pl[0] = 16'hE0E0; pl[1] = 16'hE0E0; pl[2] = 16'h5555;
        run_frame("t4e", 16'h0080, 3, ref_crc(3), 0);

        // 5: timeout inside a frame
        ev_q.delete();
        send_word(H_HI, 0); send_word(H_LO, 0); send_word(16'h0001, 0);
        send_word(16'h1111, 0); send_word(16'h2222, 0);
        repeat (63) begin @(posedge clk_in); #1; end
        chk("t5.early", crc_err, 0);
        @(posedge clk_in); #1;
        chk("t5.err", crc_err, 1);
        chk("t5.code", err_code, 4);
        m_drop++;
        @(posedge clk_in); #1;
        chk("t5.drop_cnt", frm_drop_cnt, m_drop);
        fill_valid(4);
        run_frame("t5b", 16'h0008, 4, ref_crc(4), 2);

        // 6: reset mid-payload
        ev_q.delete();
        send_word(H_HI, 0); send_word(H_LO, 0); send_word(16'h0001, 0);
        send_word(16'h3333, 1); send_word(16'h4444, 0);
        rst_n = 1'b0;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        m_ok = 0; m_drop = 0; m_held = 1'b0;
        repeat (3) begin @(posedge clk_in); #1; end
        chk("t6.events", ev_q.size(), 0);
        chk("t6.ok_cnt", frm_ok_cnt, 0);
        chk("t6.drop_cnt", frm_drop_cnt, 0);
        chk("t6.outs", {out_valid, out_ch, out_len, crc_err, crc_valid, err_code}, 0);
        fill_valid(5);
        run_frame("t6b", 16'h0040, 5, ref_crc(5), 1);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            out_ready = 1'($urandom_range(1, 0));
            repeat (2) begin @(posedge clk_in); #1; end
            if (out_ready) m_held = 1'b0;
            kind = int'($urandom_range(9, 0));
            n    = int'($urandom_range(MAXW, 1));
            chw  = 16'(1 << $urandom_range(N_CH - 1, 0));
            if (kind == 2) n = MAXW + 1;
            fill_valid(n);
            c = ref_crc(n);
            if (kind == 0) begin
                case ($urandom_range(2, 0))
                    0:       chw = 16'h0000;
                    1:       chw = 16'(1 << $urandom_range(15, N_CH));
                    default: chw = chw | 16'(1 << (($clog2(int'(chw)) + 1) % N_CH));
                endcase
            end
            if (kind == 1) begin
                do bad = rand_word(); while (bad == c);
                c = bad;
            end
            run_frame($sformatf("rnd%0d", it), chw, n, c, 3);
        end

        chk("excl", both_hi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
